// File: rtl/prog_sequence_generator.sv
// prog_sequence_generator: programmable pattern memory replayed as a valid/ready word stream.
// Define SEQGEN_DEFAULT_PATTERN_EN to preload entries 0..7 with a fixed pattern on reset.
module prog_sequence_generator #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [LW-1:0]     len,
    input  logic              mode,
    input  logic              start,
    input  logic              abort,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] data,
    output logic [AW-1:0]     index,
    output logic              busy,
    output logic              done,
    output logic              wrap
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       index_q, index_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic [LW-1:0]       len_q,   len_d;
    logic                mode_q,  mode_d;
    logic                done_q,  done_d;
    logic                wrap_q,  wrap_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [LW-1:0]       eff_len;
    logic [AW-1:0]       next_index;
    logic                last_entry;

`ifdef SEQGEN_DEFAULT_PATTERN_EN
    function automatic logic [DATA_W-1:0] default_word(input int idx);
        logic [7:0] byte_val;
        case (idx)
            0:       byte_val = 8'hAF;
            1:       byte_val = 8'hBC;
            2:       byte_val = 8'hE2;
            3:       byte_val = 8'h78;
            4:       byte_val = 8'hFF;
            5:       byte_val = 8'hE2;
            6:       byte_val = 8'h0B;
            7:       byte_val = 8'h8D;
            default: byte_val = 8'h00;
        endcase
        return DATA_W'(byte_val);
    endfunction
`endif

    assign eff_len    = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
    assign next_index = index_q + AW'(1);
    assign last_entry = (LW'(index_q) == (len_q - LW'(1)));

    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        data_d  = data_q;
        len_d   = len_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            index_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && (len != '0)) begin
                        state_d = ST_RUN;
                        len_d   = eff_len;
                        mode_d  = mode;
                        index_d = '0;
                        data_d  = mem_q[0];
                    end
                end
                ST_RUN: begin
                    if (out_ready) begin
                        if (!last_entry) begin
                            index_d = next_index;
                            data_d  = mem_q[next_index];
                        end else if (mode_q) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            index_d = '0;
                            data_d  = mem_q[0];
                            wrap_d  = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            index_q <= '0;
            data_q  <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            data_q  <= data_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    // NOTE: the pattern memory is reset deliberately so it can come up preloaded; it lives in flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef SEQGEN_DEFAULT_PATTERN_EN
                mem_q[i] <= default_word(i);
`else
                mem_q[i] <= '0;
`endif
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign out_valid = (state_q == ST_RUN);
    assign busy      = (state_q == ST_RUN);
    assign data      = data_q;
    assign index     = index_q;
    assign done      = done_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_prog_sequence_generator.sv
// Self-checking bench for prog_sequence_generator: directed vector table, hand-written corner
// sequences, and randomized stimulus against a transaction-level reference model.
module tb_prog_sequence_generator;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int AW     = 3;
    localparam int LW     = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [LW-1:0]     len;
    logic              mode;
    logic              start;
    logic              abort;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] data;
    logic [AW-1:0]     index;
    logic              busy;
    logic              done;
    logic              wrap;

    int checks   = 0;
    int failures = 0;

    prog_sequence_generator #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .len       (len),
        .mode      (mode),
        .start     (start),
        .abort     (abort),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .data      (data),
        .index     (index),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [7:0]    wr_data;
        logic [LW-1:0] len;
        logic          mode;
        logic          start;
        logic          abort;
        logic          ready;
        logic          e_valid;
        logic          e_done;
        logic          e_wrap;
        logic          chk_data;
        logic [7:0]    e_data;
        logic [AW-1:0] e_index;
    } vec_t;

    logic [7:0] reset_pat [8];

    // Reference model: a stream position over a snapshot-free pattern array.
    logic [7:0] m_mem [8];
    bit         m_run;
    int         m_idx;
    int         m_len;
    bit         m_oneshot;
    logic [7:0] m_data;
    bit         m_done;
    bit         m_wrap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_run = 0; m_idx = 0; m_len = 0; m_oneshot = 0;
            m_data = '0; m_done = 0; m_wrap = 0;
            for (int i = 0; i < 8; i++) m_mem[i] = reset_pat[i];
            return;
        end
        m_done = 0;
        m_wrap = 0;
        if (abort) begin
            m_run = 0;
            m_idx = 0;
        end else if (!m_run) begin
            if (start && len != 0) begin
                m_len     = (int'(len) > DEPTH) ? DEPTH : int'(len);
                m_oneshot = mode;
                m_run     = 1;
                m_idx     = 0;
                m_data    = m_mem[0];
            end
        end else if (out_ready) begin
            if (m_idx == m_len - 1) begin
                if (m_oneshot) begin
                    m_run  = 0;
                    m_done = 1;
                end else begin
                    m_idx  = 0;
                    m_data = m_mem[0];
                    m_wrap = 1;
                end
            end else begin
                m_idx  = m_idx + 1;
                m_data = m_mem[m_idx];
            end
        end
        if (wr_en) m_mem[wr_addr] = wr_data;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_en = 0; wr_addr = '0; wr_data = '0; len = '0;
        mode = 0; start = 0; abort = 0; out_ready = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_index"}, index, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_wrap"},  wrap, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [14];
        int   words;

`ifdef SEQGEN_DEFAULT_PATTERN_EN
        reset_pat[0] = 8'hAF; reset_pat[1] = 8'hBC; reset_pat[2] = 8'hE2; reset_pat[3] = 8'h78;
        reset_pat[4] = 8'hFF; reset_pat[5] = 8'hE2; reset_pat[6] = 8'h0B; reset_pat[7] = 8'h8D;
`else
        for (int i = 0; i < 8; i++) reset_pat[i] = 8'h00;
`endif

        // One-shot run of 11,22,33 with free-flowing then toggling out_ready.
        vecs[0]  = '{1'b1, 3'd0, 8'h11, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
        vecs[1]  = '{1'b1, 3'd1, 8'h22, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
        vecs[2]  = '{1'b1, 3'd2, 8'h33, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
        vecs[3]  = '{1'b0, 3'd0, 8'h00, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 3'd0};
        vecs[4]  = '{1'b0, 3'd0, 8'h00, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 3'd1};
        vecs[5]  = '{1'b0, 3'd0, 8'h00, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 3'd2};
        vecs[6]  = '{1'b0, 3'd0, 8'h00, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 3'd0};
        vecs[7]  = '{1'b0, 3'd0, 8'h00, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 3'd0};
        vecs[8]  = '{1'b0, 3'd0, 8'h00, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 3'd0};
        vecs[9]  = '{1'b0, 3'd0, 8'h00, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 3'd1};
        vecs[10] = '{1'b0, 3'd0, 8'h00, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 3'd1};
        vecs[11] = '{1'b0, 3'd0, 8'h00, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 3'd1};
        vecs[12] = '{1'b0, 3'd0, 8'h00, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 3'd2};
        vecs[13] = '{1'b0, 3'd0, 8'h00, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 3'd0};

        clear_inputs();
        reset = 1;
        tick();
        tick();
        check_idle("reset");
        check("reset_data", data, 0);
        reset = 0;

        // Loop over the full reset pattern; wrap follows acceptance of the last entry.
        len = 4'd8; mode = 0; start = 1; out_ready = 1;
        tick();
        start = 0;
        for (int k = 0; k < 9; k++) begin
            check("loop_valid", out_valid, 1);
            check("loop_data",  data, reset_pat[k % 8]);
            check("loop_index", index, k % 8);
            check("loop_wrap",  wrap, (k == 8) ? 1 : 0);
            tick();
        end
        abort = 1;
        tick();
        abort = 0;
        check_idle("loop_abort");

        for (int v = 0; v < 14; v++) begin
            wr_en = vecs[v].wr_en; wr_addr = vecs[v].wr_addr; wr_data = vecs[v].wr_data;
            len = vecs[v].len; mode = vecs[v].mode; start = vecs[v].start;
            abort = vecs[v].abort; out_ready = vecs[v].ready;
            tick();
            check("vec_valid", out_valid, vecs[v].e_valid);
            check("vec_busy",  busy, vecs[v].e_valid);
            check("vec_done",  done, vecs[v].e_done);
            check("vec_wrap",  wrap, vecs[v].e_wrap);
            if (vecs[v].chk_data) check("vec_data", data, vecs[v].e_data);
            if (vecs[v].e_valid)  check("vec_index", index, vecs[v].e_index);
        end
        clear_inputs();

        // Abort at index 2 with out_ready high and start also asserted.
        len = 4'd4; mode = 0; start = 1; out_ready = 1;
        tick();
        start = 0;
        tick();
        tick();
        check("abort_pre_index", index, 2);
        check("abort_pre_data",  data, 8'h33);
        abort = 1; start = 1;
        tick();
        abort = 0; start = 0;
        check_idle("abort");
        tick();
        check_idle("abort_next");

        // Zero length start is ignored.
        len = 4'd0; start = 1;
        tick();
        start = 0;
        check_idle("len0");
        tick();
        check_idle("len0_next");

        // Length larger than DEPTH clamps to DEPTH words.
        len = 4'd15; mode = 1; start = 1; out_ready = 1;
        tick();
        start = 0;
        words = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (out_valid) words++;
            tick();
        end
        check("clamp_words", words, 8);
        check("clamp_done",  done, 1);
        check("clamp_valid", out_valid, 0);

        // Reset at the last loop entry with acceptance pending: no wrap, all outputs cleared.
        len = 4'd4; mode = 0; start = 1; out_ready = 1;
        tick();
        start = 0;
        tick(); tick(); tick();
        check("rst_mid_index", index, 3);
        reset = 1;
        tick();
        reset = 0;
        check_idle("rst_mid");
        check("rst_mid_data", data, 0);

        // Writes under a presented word, and a write coinciding with the load of that entry.
        out_ready = 0; len = 4'd4; mode = 0; start = 1;
        tick();
        start = 0;
        check("wr_first_data", data, reset_pat[0]);
        out_ready = 1;
        tick();
        check("wr_e1_data", data, reset_pat[1]);
        out_ready = 0; wr_en = 1; wr_addr = 3'd1; wr_data = 8'h5A;
        tick();
        check("wr_hold1_data", data, reset_pat[1]);
        wr_addr = 3'd2; wr_data = 8'h6B;
        tick();
        check("wr_hold2_data",  data, reset_pat[1]);
        check("wr_hold2_index", index, 1);
        wr_en = 0; out_ready = 1;
        tick();
        check("wr_new_data", data, 8'h6B);
        wr_en = 1; wr_addr = 3'd3; wr_data = 8'hC4;
        tick();
        wr_en = 0;
        check("wr_same_edge_data", data, reset_pat[3]);
        tick();
        check("wr_wrap",    wrap, 1);
        check("wr_wrap_data", data, reset_pat[0]);
        tick();
        check("wr_e1_new", data, 8'h5A);
        tick(); tick();
        check("wr_e3_new", data, 8'hC4);
        clear_inputs();

        // Randomized traffic against the reference model.
        reset = 1;
        tick();
        reset = 0;
        for (int n = 0; n < 2000; n++) begin
            reset     = ($urandom_range(0, 199) == 0);
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_addr   = AW'($urandom_range(0, 7));
            wr_data   = 8'($urandom);
            len       = LW'($urandom_range(0, 15));
            mode      = 1'($urandom_range(0, 1));
            start     = ($urandom_range(0, 7) == 0);
            abort     = ($urandom_range(0, 29) == 0);
            out_ready = 1'($urandom_range(0, 1));
            tick();
            check("rnd_valid", out_valid, m_run);
            check("rnd_busy",  busy, m_run);
            check("rnd_data",  data, m_data);
            check("rnd_done",  done, m_done);
            check("rnd_wrap",  wrap, m_wrap);
            if (m_run) check("rnd_index", index, m_idx);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_sequence_generator.md
PROG_SEQUENCE_GENERATOR -- requirements
Module: prog_sequence_generator

Interface
REQ-001 Parameter DATA_W, default 8, width of each sequence word.
REQ-002 Parameter DEPTH, default 8, number of pattern entries, legal range 2..256; AW = $clog2(DEPTH), LW = $clog2(DEPTH+1).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  pattern write strobe.
REQ-006 wr_addr  input  AW  pattern write index.
REQ-007 wr_data  input  DATA_W  pattern write word.
REQ-008 len  input  LW  active sequence length, sampled at start.
REQ-009 mode  input  1  0 = loop, 1 = one-shot; sampled at start.
REQ-010 start  input  1  begin sequence from entry 0.
REQ-011 abort  input  1  stop immediately, return to IDLE.
REQ-012 out_ready  input  1  consumer accepts data this cycle.
REQ-013 out_valid  output  1  data holds a valid sequence word.
REQ-014 data  output  DATA_W  registered sequence word.
REQ-015 index  output  AW  entry number currently presented.
REQ-016 busy  output  1  high in RUN.
REQ-017 done  output  1  one-cycle pulse at one-shot completion.
REQ-018 wrap  output  1  one-cycle pulse when loop mode returns to entry 0.

Function
REQ-019 States: IDLE, RUN. Handshake: a word is accepted when out_valid && out_ready in the same cycle.
REQ-020 IDLE: if start && effective length != 0, go to RUN next cycle with data = mem[0], index = 0, out_valid = 1, busy = 1. Latency from start to first valid word: 1 cycle.
REQ-021 Effective length = min(len, DEPTH), latched at start. If len == 0, start is ignored.
REQ-022 RUN without acceptance: data, index, and out_valid hold stable.
REQ-023 RUN with acceptance at index < len_latched-1: next cycle index+1, data = mem[index+1].
REQ-024 Acceptance at last index, loop mode: next cycle index = 0, data = mem[0], and wrap pulses for one cycle.
REQ-025 Acceptance at last index, one-shot mode: next cycle goes to IDLE with out_valid = 0, busy = 0, and done pulses for one cycle.
REQ-026 start while in RUN is ignored.
REQ-027 abort has priority over start and handshake: next cycle goes to IDLE with out_valid = 0, index = 0, and no done or wrap pulse. This is the only case in which out_valid may fall without acceptance.
REQ-028 Writes are accepted in any state and occur on the edge they are presented.
- data is registered on load, so a write to the currently presented entry does not alter data.
- A write to mem[k] on the same edge that loads mem[k] presents the old value.
REQ-029 data holds its last value in IDLE.

Reset
REQ-030 reset dominates all inputs and produces: state IDLE, out_valid = 0, data = 0, index = 0, busy = 0, done = 0, wrap = 0, latched len/mode = 0.
REQ-031 Reset mid-RUN discards the current word with no done or wrap pulse.
REQ-032 Pattern memory is initialised on reset per REQ-033/REQ-034.

Configuration
REQ-033 Macro SEQGEN_DEFAULT_PATTERN_EN defined: reset loads entries 0..7 with AF, BC, E2, 78, FF, E2, 0B, 8D (truncated or zero-extended to DATA_W; entries that do not exist when DEPTH < 8 are skipped). Remaining entries reset to 0.
REQ-034 Macro SEQGEN_DEFAULT_PATTERN_EN undefined: reset clears all entries to 0.

Verification
REQ-035 Macro defined, defaults, reset, len = 8, mode = 0, start, out_ready = 1 -> data AF, BC, E2, 78, FF, E2, 0B, 8D, AF...; wrap pulses the cycle after the first 8D is accepted.
REQ-036 Write 11, 22, 33 to entries 0..2, len = 3, mode = 1, start, out_ready = 1 -> 11, 22, 33 on consecutive cycles; done pulses once; then out_valid = 0 and busy = 0.
REQ-037 Same setup, out_ready toggling 1,0,0,1 -> data 22 holds stable for 3 cycles; total of 3 accepted words.
REQ-038 Loop run, abort asserted at index 2 with out_ready = 1 -> next cycle out_valid = 0, index = 0, no done or wrap pulse; start is ignored on the abort cycle.
REQ-039 len = 0 with start -> stays in IDLE. len = 15 with DEPTH = 8 -> clamped to 8 entries. reset asserted mid-RUN -> all outputs at reset values the next cycle.
REQ-040 While RUN presents entry 1, write entry 1 = 5A and entry 2 = 6B -> data stays at the old entry-1 value, then shows 6B after acceptance.
